// File: rtl/execute_unit.sv
// -----------------------------------------------------------------------------
// execute_unit
//   EX stage of the 5-stage pipeline. Computes the ALU result, the zero flag and
//   the branch target. It registers these, together with the pass-through
//   control, into the EX/MEM pipeline register.
//
//   MUL (opcode 10) is handled by a shift-add engine that takes NB_DATA
//   iterations. While it runs, o_stall holds the ID/EX register upstream.
//
//   Optional feature, enabled with the macro EX_OVERFLOW_TRAP_EN:
//     - Adds the registered output o_overflow.
//     - A signed ADD/SUB overflow sets o_overflow for one cycle and suppresses
//       the register-file and memory writes of that instruction.
//
// Ports
//   i_clock, i_reset          clock, synchronous active-high reset
//   i_valid, i_flush          real instruction present / squash stage
//   i_rs_data, i_rt_data      operand A, operand B source (also store data)
//   i_imm, i_alu_src          sign-extended immediate, B select (1 = imm)
//   i_alu_op                  operation code
//   i_pc_next                 PC+1 of the instruction
//   i_is_branch .. i_rf_wr_addr   pass-through control
//   o_alu_result, o_alu_zero  registered result and (result == 0)
//   o_rt_data, o_branch_addr  registered store data and branch target
//   o_is_branch .. o_rf_wr_addr   registered control
//   o_overflow                (EX_OVERFLOW_TRAP_EN only) signed overflow flag
//   o_stall                   combinational; upstream holds ID/EX while high
// -----------------------------------------------------------------------------
module execute_unit #(
    parameter int NB_ADDR   = 5,
    parameter int NB_DATA   = 2**NB_ADDR,
    parameter int NB_ALU_OP = 4
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_valid,
    input  logic                 i_flush,
    input  logic [NB_DATA-1:0]   i_rs_data,
    input  logic [NB_DATA-1:0]   i_rt_data,
    input  logic [NB_DATA-1:0]   i_imm,
    input  logic                 i_alu_src,
    input  logic [NB_ALU_OP-1:0] i_alu_op,
    input  logic [NB_ADDR-1:0]   i_pc_next,
    input  logic                 i_is_branch,
    input  logic                 i_mem_wr_enb,
    input  logic                 i_mem_rd_enb,
    input  logic                 i_rf_wr_enb,
    input  logic                 i_rf_wr_data_src,
    input  logic [NB_ADDR-1:0]   i_rf_wr_addr,
    output logic [NB_DATA-1:0]   o_alu_result,
    output logic                 o_alu_zero,
    output logic [NB_DATA-1:0]   o_rt_data,
    output logic [NB_ADDR-1:0]   o_branch_addr,
    output logic                 o_is_branch,
    output logic                 o_mem_wr_enb,
    output logic                 o_mem_rd_enb,
    output logic                 o_rf_wr_enb,
    output logic                 o_rf_wr_data_src,
    output logic [NB_ADDR-1:0]   o_rf_wr_addr,
`ifdef EX_OVERFLOW_TRAP_EN
    output logic                 o_overflow,
`endif
    output logic                 o_stall
);

    localparam int NB_CNT = $clog2(NB_DATA);
    localparam logic [NB_CNT-1:0] LAST_STEP = NB_CNT'(NB_DATA - 1);

    localparam logic [NB_ALU_OP-1:0] OP_ADD = NB_ALU_OP'(0);
    localparam logic [NB_ALU_OP-1:0] OP_SUB = NB_ALU_OP'(1);
    localparam logic [NB_ALU_OP-1:0] OP_AND = NB_ALU_OP'(2);
    localparam logic [NB_ALU_OP-1:0] OP_OR  = NB_ALU_OP'(3);
    localparam logic [NB_ALU_OP-1:0] OP_XOR = NB_ALU_OP'(4);
    localparam logic [NB_ALU_OP-1:0] OP_NOR = NB_ALU_OP'(5);
    localparam logic [NB_ALU_OP-1:0] OP_SLT = NB_ALU_OP'(6);
    localparam logic [NB_ALU_OP-1:0] OP_SLL = NB_ALU_OP'(7);
    localparam logic [NB_ALU_OP-1:0] OP_SRL = NB_ALU_OP'(8);
    localparam logic [NB_ALU_OP-1:0] OP_SRA = NB_ALU_OP'(9);
    localparam logic [NB_ALU_OP-1:0] OP_MUL = NB_ALU_OP'(10);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t              state_reg;
    logic [NB_CNT-1:0]   count_reg;
    logic [NB_DATA-1:0]  mcand_reg;     // multiplicand, shifted left each step
    logic [NB_DATA-1:0]  mplier_reg;    // multiplier, shifted right each step
    logic [NB_DATA-1:0]  acc_reg;       // partial product

    // Instruction context captured when a multiply is accepted
    logic [NB_DATA-1:0]  sh_rt_data_reg;
    logic [NB_ADDR-1:0]  sh_branch_addr_reg;
    logic                sh_is_branch_reg;
    logic                sh_mem_wr_enb_reg;
    logic                sh_mem_rd_enb_reg;
    logic                sh_rf_wr_enb_reg;
    logic                sh_rf_wr_data_src_reg;
    logic [NB_ADDR-1:0]  sh_rf_wr_addr_reg;

    logic [NB_DATA-1:0]  alu_b;
    logic [NB_ADDR-1:0]  shamt;
    logic [NB_DATA-1:0]  add_sum;
    logic [NB_DATA-1:0]  sub_diff;
    logic [NB_DATA-1:0]  alu_result;
    logic [NB_ADDR-1:0]  branch_target;
    logic [NB_DATA-1:0]  acc_step;
    logic                mul_accept;

    // Next values of the EX/MEM register; all-zero means bubble
    logic                load_out;
    logic [NB_DATA-1:0]  result_next;
    logic                zero_next;
    logic [NB_DATA-1:0]  rt_data_next;
    logic [NB_ADDR-1:0]  branch_addr_next;
    logic                is_branch_next;
    logic                mem_wr_enb_next;
    logic                mem_rd_enb_next;
    logic                rf_wr_enb_next;
    logic                rf_wr_data_src_next;
    logic [NB_ADDR-1:0]  rf_wr_addr_next;
`ifdef EX_OVERFLOW_TRAP_EN
    logic                ovf_comb;
    logic                overflow_next;
`endif

    assign alu_b         = i_alu_src ? i_imm : i_rt_data;
    assign shamt         = alu_b[NB_ADDR-1:0];
    assign add_sum       = i_rs_data + alu_b;
    assign sub_diff      = i_rs_data - alu_b;
    assign branch_target = i_pc_next + i_imm[NB_ADDR-1:0];
    // The final shift-add step is folded into the value latched at the last count
    assign acc_step      = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
    assign mul_accept    = (state_reg == ST_IDLE) && i_valid && !i_flush &&
                           (i_alu_op == OP_MUL);

`ifdef EX_OVERFLOW_TRAP_EN
    // Signed overflow: operands of compatible sign produce a result of the other sign
    always_comb begin
        ovf_comb = 1'b0;
        if (i_alu_op == OP_ADD)
            ovf_comb = (i_rs_data[NB_DATA-1] == alu_b[NB_DATA-1]) &&
                       (add_sum[NB_DATA-1] != i_rs_data[NB_DATA-1]);
        else if (i_alu_op == OP_SUB)
            ovf_comb = (i_rs_data[NB_DATA-1] != alu_b[NB_DATA-1]) &&
                       (sub_diff[NB_DATA-1] != i_rs_data[NB_DATA-1]);
    end
`endif

    always_comb begin
        alu_result = '0;
        case (i_alu_op)
            OP_ADD: alu_result = add_sum;
            OP_SUB: alu_result = sub_diff;
            OP_AND: alu_result = i_rs_data & alu_b;
            OP_OR:  alu_result = i_rs_data | alu_b;
            OP_XOR: alu_result = i_rs_data ^ alu_b;
            OP_NOR: alu_result = ~(i_rs_data | alu_b);
            OP_SLT: alu_result = {{(NB_DATA-1){1'b0}},
                                  ($signed(i_rs_data) < $signed(alu_b))};
            OP_SLL: alu_result = i_rs_data << shamt;
            OP_SRL: alu_result = i_rs_data >> shamt;
            OP_SRA: alu_result = $unsigned($signed(i_rs_data) >>> shamt);
            default: alu_result = '0;   // MUL goes through the iterative engine
        endcase
    end

    always_comb begin
        load_out            = 1'b0;
        result_next         = '0;
        zero_next           = 1'b0;
        rt_data_next        = '0;
        branch_addr_next    = '0;
        is_branch_next      = 1'b0;
        mem_wr_enb_next     = 1'b0;
        mem_rd_enb_next     = 1'b0;
        rf_wr_enb_next      = 1'b0;
        rf_wr_data_src_next = 1'b0;
        rf_wr_addr_next     = '0;
`ifdef EX_OVERFLOW_TRAP_EN
        overflow_next       = 1'b0;
`endif
        case (state_reg)
            ST_IDLE: begin
                // Bubble unless a single-cycle instruction is present
                load_out = 1'b1;
                if (i_valid && !i_flush && (i_alu_op != OP_MUL)) begin
                    result_next         = alu_result;
                    zero_next           = (alu_result == '0);
                    rt_data_next        = i_rt_data;
                    branch_addr_next    = branch_target;
                    is_branch_next      = i_is_branch;
                    mem_wr_enb_next     = i_mem_wr_enb;
                    mem_rd_enb_next     = i_mem_rd_enb;
                    rf_wr_enb_next      = i_rf_wr_enb;
                    rf_wr_data_src_next = i_rf_wr_data_src;
                    rf_wr_addr_next     = i_rf_wr_addr;
`ifdef EX_OVERFLOW_TRAP_EN
                    overflow_next       = ovf_comb;
                    if (ovf_comb) begin
                        rf_wr_enb_next  = 1'b0;
                        mem_wr_enb_next = 1'b0;
                    end
`endif
                end
            end
            ST_BUSY: begin
                if (i_flush) begin
                    load_out = 1'b1;
                end else if (count_reg == LAST_STEP) begin
                    load_out            = 1'b1;
                    result_next         = acc_step;
                    zero_next           = (acc_step == '0);
                    rt_data_next        = sh_rt_data_reg;
                    branch_addr_next    = sh_branch_addr_reg;
                    is_branch_next      = sh_is_branch_reg;
                    mem_wr_enb_next     = sh_mem_wr_enb_reg;
                    mem_rd_enb_next     = sh_mem_rd_enb_reg;
                    rf_wr_enb_next      = sh_rf_wr_enb_reg;
                    rf_wr_data_src_next = sh_rf_wr_data_src_reg;
                    rf_wr_addr_next     = sh_rf_wr_addr_reg;
                end
            end
            default: load_out = 1'b1;
        endcase
    end

    // Stall covers the acceptance cycle and every step except the last one
    assign o_stall = !i_reset && !i_flush &&
                     (mul_accept ||
                      ((state_reg == ST_BUSY) && (count_reg != LAST_STEP)));

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_reg             <= ST_IDLE;
            count_reg             <= '0;
            mcand_reg             <= '0;
            mplier_reg            <= '0;
            acc_reg               <= '0;
            sh_rt_data_reg        <= '0;
            sh_branch_addr_reg    <= '0;
            sh_is_branch_reg      <= 1'b0;
            sh_mem_wr_enb_reg     <= 1'b0;
            sh_mem_rd_enb_reg     <= 1'b0;
            sh_rf_wr_enb_reg      <= 1'b0;
            sh_rf_wr_data_src_reg <= 1'b0;
            sh_rf_wr_addr_reg     <= '0;
            o_alu_result          <= '0;
            o_alu_zero            <= 1'b0;
            o_rt_data             <= '0;
            o_branch_addr         <= '0;
            o_is_branch           <= 1'b0;
            o_mem_wr_enb          <= 1'b0;
            o_mem_rd_enb          <= 1'b0;
            o_rf_wr_enb           <= 1'b0;
            o_rf_wr_data_src      <= 1'b0;
            o_rf_wr_addr          <= '0;
`ifdef EX_OVERFLOW_TRAP_EN
            o_overflow            <= 1'b0;
`endif
        end else begin
            if (load_out) begin
                o_alu_result     <= result_next;
                o_alu_zero       <= zero_next;
                o_rt_data        <= rt_data_next;
                o_branch_addr    <= branch_addr_next;
                o_is_branch      <= is_branch_next;
                o_mem_wr_enb     <= mem_wr_enb_next;
                o_mem_rd_enb     <= mem_rd_enb_next;
                o_rf_wr_enb      <= rf_wr_enb_next;
                o_rf_wr_data_src <= rf_wr_data_src_next;
                o_rf_wr_addr     <= rf_wr_addr_next;
`ifdef EX_OVERFLOW_TRAP_EN
                o_overflow       <= overflow_next;
`endif
            end
            case (state_reg)
                ST_IDLE: begin
                    if (mul_accept) begin
                        state_reg             <= ST_BUSY;
                        count_reg             <= '0;
                        acc_reg               <= '0;
                        mcand_reg             <= i_rs_data;
                        mplier_reg            <= alu_b;
                        sh_rt_data_reg        <= i_rt_data;
                        sh_branch_addr_reg    <= branch_target;
                        sh_is_branch_reg      <= i_is_branch;
                        sh_mem_wr_enb_reg     <= i_mem_wr_enb;
                        sh_mem_rd_enb_reg     <= i_mem_rd_enb;
                        sh_rf_wr_enb_reg      <= i_rf_wr_enb;
                        sh_rf_wr_data_src_reg <= i_rf_wr_data_src;
                        sh_rf_wr_addr_reg     <= i_rf_wr_addr;
                    end
                end
                ST_BUSY: begin
                    if (i_flush) begin
                        state_reg <= ST_IDLE;
                        count_reg <= '0;
                    end else begin
                        acc_reg    <= acc_step;
                        mcand_reg  <= mcand_reg << 1;
                        mplier_reg <= mplier_reg >> 1;
                        if (count_reg == LAST_STEP) begin
                            state_reg <= ST_IDLE;
                            count_reg <= '0;
                        end else begin
                            count_reg <= count_reg + 1'b1;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_execute_unit.sv
module tb_execute_unit;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_valid;
    logic        i_flush;
    logic [31:0] i_rs_data;
    logic [31:0] i_rt_data;
    logic [31:0] i_imm;
    logic        i_alu_src;
    logic [3:0]  i_alu_op;
    logic [4:0]  i_pc_next;
    logic        i_is_branch;
    logic        i_mem_wr_enb;
    logic        i_mem_rd_enb;
    logic        i_rf_wr_enb;
    logic        i_rf_wr_data_src;
    logic [4:0]  i_rf_wr_addr;
    logic [31:0] o_alu_result;
    logic        o_alu_zero;
    logic [31:0] o_rt_data;
    logic [4:0]  o_branch_addr;
    logic        o_is_branch;
    logic        o_mem_wr_enb;
    logic        o_mem_rd_enb;
    logic        o_rf_wr_enb;
    logic        o_rf_wr_data_src;
    logic [4:0]  o_rf_wr_addr;
    logic        o_stall;
`ifdef EX_OVERFLOW_TRAP_EN
    logic        o_overflow;
`endif

    execute_unit #(.NB_ADDR(5), .NB_DATA(32), .NB_ALU_OP(4)) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .i_flush(i_flush),
        .i_rs_data(i_rs_data), .i_rt_data(i_rt_data), .i_imm(i_imm),
        .i_alu_src(i_alu_src), .i_alu_op(i_alu_op), .i_pc_next(i_pc_next),
        .i_is_branch(i_is_branch), .i_mem_wr_enb(i_mem_wr_enb),
        .i_mem_rd_enb(i_mem_rd_enb), .i_rf_wr_enb(i_rf_wr_enb),
        .i_rf_wr_data_src(i_rf_wr_data_src), .i_rf_wr_addr(i_rf_wr_addr),
        .o_alu_result(o_alu_result), .o_alu_zero(o_alu_zero), .o_rt_data(o_rt_data),
        .o_branch_addr(o_branch_addr), .o_is_branch(o_is_branch),
        .o_mem_wr_enb(o_mem_wr_enb), .o_mem_rd_enb(o_mem_rd_enb),
        .o_rf_wr_enb(o_rf_wr_enb), .o_rf_wr_data_src(o_rf_wr_data_src),
        .o_rf_wr_addr(o_rf_wr_addr),
`ifdef EX_OVERFLOW_TRAP_EN
        .o_overflow(o_overflow),
`endif
        .o_stall(o_stall)
    );

    always #5 i_clock = ~i_clock;

    int cyc = 0;
    always @(posedge i_clock) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] res;
        logic        zero;
        logic [31:0] rt;
        logic [4:0]  br;
        logic [4:0]  ctl;   // {is_branch, mem_wr, mem_rd, rf_wr, rf_src}
        logic [4:0]  wa;
        logic        ovf;
    } exp_t;

    typedef struct {
        int   cyc;
        logic val;
    } stall_t;

    exp_t   out_q[$];
    stall_t stall_q[$];
    int     tests = 0;
    int     fails = 0;

    // ---------------- scoreboard monitor ----------------
    exp_t   e;
    stall_t s;
    logic   ovf_act;
    always @(negedge i_clock) begin
        while (stall_q.size() > 0 && stall_q[0].cyc <= cyc) begin
            s = stall_q.pop_front();
            tests++;
            if (s.cyc != cyc || o_stall !== s.val) begin
                fails++;
                $display("FAIL stall cyc=%0d (due %0d): got %0b expected %0b",
                         cyc, s.cyc, o_stall, s.val);
            end
        end
        while (out_q.size() > 0 && out_q[0].cyc <= cyc) begin
            e = out_q.pop_front();
`ifdef EX_OVERFLOW_TRAP_EN
            ovf_act = o_overflow;
`else
            ovf_act = e.ovf;
`endif
            tests++;
            if (e.cyc != cyc || o_alu_result !== e.res || o_alu_zero !== e.zero ||
                o_rt_data !== e.rt || o_branch_addr !== e.br ||
                {o_is_branch, o_mem_wr_enb, o_mem_rd_enb, o_rf_wr_enb, o_rf_wr_data_src} !== e.ctl ||
                o_rf_wr_addr !== e.wa || ovf_act !== e.ovf) begin
                fails++;
                $display("FAIL outputs cyc=%0d (due %0d): got res=%h z=%0b rt=%h br=%0d ctl=%b wa=%0d ovf=%0b expected res=%h z=%0b rt=%h br=%0d ctl=%b wa=%0d ovf=%0b",
                         cyc, e.cyc, o_alu_result, o_alu_zero, o_rt_data, o_branch_addr,
                         {o_is_branch, o_mem_wr_enb, o_mem_rd_enb, o_rf_wr_enb, o_rf_wr_data_src},
                         o_rf_wr_addr, ovf_act, e.res, e.zero, e.rt, e.br, e.ctl, e.wa, e.ovf);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cycle();
        @(posedge i_clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic f, input logic [31:0] a,
                         input logic [31:0] rt, input logic [31:0] imm, input logic src,
                         input logic [3:0] op, input logic [4:0] pc,
                         input logic [4:0] ctl, input logic [4:0] wa);
        i_valid = v; i_flush = f; i_rs_data = a; i_rt_data = rt; i_imm = imm;
        i_alu_src = src; i_alu_op = op; i_pc_next = pc;
        {i_is_branch, i_mem_wr_enb, i_mem_rd_enb, i_rf_wr_enb, i_rf_wr_data_src} = ctl;
        i_rf_wr_addr = wa;
    endtask

    task automatic exp_out(input int c, input logic [31:0] res, input logic zero,
                           input logic [31:0] rt, input logic [4:0] br,
                           input logic [4:0] ctl, input logic [4:0] wa, input logic ovf);
        exp_t x;
        x.cyc = c; x.res = res; x.zero = zero; x.rt = rt; x.br = br;
        x.ctl = ctl; x.wa = wa; x.ovf = ovf;
        out_q.push_back(x);
    endtask

    task automatic exp_bubble(input int c);
        exp_out(c, 32'h0, 1'b0, 32'h0, 5'd0, 5'b0, 5'd0, 1'b0);
    endtask

    task automatic exp_stall(input int c, input logic v);
        stall_t x;
        x.cyc = c; x.val = v;
        stall_q.push_back(x);
    endtask

    // Single-cycle op issued in the current cycle, checked one cycle later
    task automatic single(input logic [31:0] a, input logic [31:0] rt,
                          input logic [31:0] imm, input logic src, input logic [3:0] op,
                          input logic [4:0] pc, input logic [4:0] ctl, input logic [4:0] wa,
                          input logic [31:0] res, input logic zero, input logic [4:0] br,
                          input logic [4:0] ectl, input logic ovf);
        drive(1'b1, 1'b0, a, rt, imm, src, op, pc, ctl, wa);
        exp_stall(cyc, 1'b0);
        exp_out(cyc + 1, res, zero, rt, br, ectl, wa, ovf);
        next_cycle();
    endtask

    // Runs a full multiply; garbage ADDs presented while busy must be ignored
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] pc, input logic [31:0] imm,
                           input logic [4:0] ctl, input logic [4:0] wa,
                           input logic [31:0] prod, input logic [4:0] br);
        int t;
        t = cyc;
        drive(1'b1, 1'b0, a, b, imm, 1'b0, 4'd10, pc, ctl, wa);
        exp_stall(t, 1'b1);
        exp_bubble(t + 1);
        next_cycle();
        for (int k = 1; k <= 32; k++) begin
            drive(1'b1, 1'b0, 32'h1111 * k, 32'h5, 32'h3, 1'b0, 4'd0, 5'd7, 5'b11111, 5'd1);
            exp_stall(t + k, (k < 32));
            if (k < 32) exp_bubble(t + k + 1);
            else        exp_out(t + 33, prod, (prod == 32'h0), b, br, ctl, wa, 1'b0);
            next_cycle();
        end
    endtask

    localparam logic [31:0] VA = 32'hF0F0_1234;
    localparam logic [31:0] VB = 32'h0FF0_00FF;

    initial begin
        int t;
        i_reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 4'd0, 5'd0, 5'b0, 5'd0);
        next_cycle();

        // Reset state, then reset for 2 cycles in the middle of a multiply
        exp_bubble(cyc);
        i_reset = 1'b0;
        drive(1'b1, 1'b0, 32'd5, 32'd7, 32'h0, 1'b0, 4'd10, 5'd0, 5'b00010, 5'd2);
        exp_stall(cyc, 1'b1); exp_bubble(cyc + 1);
        next_cycle();
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 4'd0, 5'd0, 5'b0, 5'd0);
            exp_stall(cyc, 1'b1); exp_bubble(cyc + 1);
            next_cycle();
        end
        for (int k = 0; k < 2; k++) begin
            i_reset = 1'b1;
            drive(1'b1, 1'b0, 32'd9, 32'd9, 32'h0, 1'b0, 4'd10, 5'd1, 5'b11111, 5'd4);
            exp_stall(cyc, 1'b0); exp_bubble(cyc + 1);
            next_cycle();
        end
        i_reset = 1'b0;

        // ADD 7 + imm(-7): zero result, control passes through
        single(32'h7, 32'h55, 32'hFFFF_FFF9, 1'b1, 4'd0, 5'd0, 5'b00010, 5'd3,
               32'h0, 1'b1, 5'd25, 5'b00010, 1'b0);
        // Branch: SUB 4-4, pc_next 30 + 5 wraps to 3
        single(32'h4, 32'h4, 32'h5, 1'b0, 4'd1, 5'd30, 5'b10000, 5'd0,
               32'h0, 1'b1, 5'd3, 5'b10000, 1'b0);
        single(VA, VB, 32'h0, 1'b0, 4'd2, 5'd0, 5'b00110, 5'd5, 32'h00F0_0034, 1'b0, 5'd0, 5'b00110, 1'b0);
        single(VA, VB, 32'h0, 1'b0, 4'd3, 5'd0, 5'b00011, 5'd6, 32'hFFF0_12FF, 1'b0, 5'd0, 5'b00011, 1'b0);
        single(VA, VB, 32'h0, 1'b0, 4'd4, 5'd0, 5'b01000, 5'd7, 32'hFF00_12CB, 1'b0, 5'd0, 5'b01000, 1'b0);
        single(VA, VB, 32'h0, 1'b0, 4'd5, 5'd0, 5'b00010, 5'd8, 32'h000F_ED00, 1'b0, 5'd0, 5'b00010, 1'b0);
        single(32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 4'd6, 5'd0, 5'b00010, 5'd9, 32'h1, 1'b0, 5'd0, 5'b00010, 1'b0);
        single(32'h8000_0001, 32'h0, 32'h24, 1'b1, 4'd7, 5'd0, 5'b00010, 5'd10, 32'h10, 1'b0, 5'd4, 5'b00010, 1'b0);
        single(32'h8000_0000, 32'd31, 32'h0, 1'b0, 4'd8, 5'd0, 5'b00010, 5'd11, 32'h1, 1'b0, 5'd0, 5'b00010, 1'b0);
        single(32'h8000_0000, 32'd4, 32'h0, 1'b0, 4'd9, 5'd0, 5'b00010, 5'd12, 32'hF800_0000, 1'b0, 5'd0, 5'b00010, 1'b0);
        single(32'd5, 32'd6, 32'h0, 1'b0, 4'd12, 5'd0, 5'b00010, 5'd13, 32'h0, 1'b1, 5'd0, 5'b00010, 1'b0);
        single(32'h0, 32'h1, 32'h0, 1'b0, 4'd1, 5'd0, 5'b00010, 5'd14, 32'hFFFF_FFFF, 1'b0, 5'd0, 5'b00010, 1'b0);
        // Signed overflow on ADD
`ifdef EX_OVERFLOW_TRAP_EN
        single(32'h7FFF_FFFF, 32'h1, 32'h0, 1'b0, 4'd0, 5'd0, 5'b01010, 5'd15,
               32'h8000_0000, 1'b0, 5'd0, 5'b00000, 1'b1);
`else
        single(32'h7FFF_FFFF, 32'h1, 32'h0, 1'b0, 4'd0, 5'd0, 5'b01010, 5'd15,
               32'h8000_0000, 1'b0, 5'd0, 5'b01010, 1'b0);
`endif
        // Bubbles: no valid, and flush of a valid instruction
        drive(1'b0, 1'b0, 32'h3, 32'h3, 32'h0, 1'b0, 4'd0, 5'd2, 5'b11111, 5'd16);
        exp_stall(cyc, 1'b0); exp_bubble(cyc + 1);
        next_cycle();
        drive(1'b1, 1'b1, 32'h3, 32'h3, 32'h0, 1'b0, 4'd10, 5'd2, 5'b11111, 5'd16);
        exp_stall(cyc, 1'b0); exp_bubble(cyc + 1);
        next_cycle();

        // Multiply, then a back-to-back multiply
        run_mul(32'h0001_2345, 32'h100, 5'd3, 32'h2, 5'b00010, 5'd9, 32'h0123_4500, 5'd5);
        run_mul(32'd3, 32'd5, 5'd31, 32'h1, 5'b00011, 5'd17, 32'd15, 5'd0);

        // Multiply flushed at count 10, followed by ADD 1+1
        t = cyc;
        drive(1'b1, 1'b0, 32'h0001_2345, 32'h100, 32'h0, 1'b0, 4'd10, 5'd0, 5'b00010, 5'd9);
        exp_stall(t, 1'b1); exp_bubble(t + 1);
        next_cycle();
        for (int k = 1; k <= 10; k++) begin
            drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 4'd0, 5'd0, 5'b0, 5'd0);
            exp_stall(t + k, 1'b1); exp_bubble(t + k + 1);
            next_cycle();
        end
        drive(1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 4'd0, 5'd0, 5'b0, 5'd0);
        exp_stall(cyc, 1'b0); exp_bubble(cyc + 1);
        next_cycle();
        single(32'h1, 32'h1, 32'h0, 1'b0, 4'd0, 5'd0, 5'b00010, 5'd18, 32'h2, 1'b0, 5'd0, 5'b00010, 1'b0);

        drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 4'd0, 5'd0, 5'b0, 5'd0);
        for (int i = 0; i < 20 && (out_q.size() > 0 || stall_q.size() > 0); i++)
            next_cycle();
        next_cycle();
        if (out_q.size() > 0 || stall_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d output and %0d stall expectations left, required 0",
                     out_q.size(), stall_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
